keypad_matrix_scanner: RTL and testbench
========================================

KEYPAD_MATRIX_SCANNER -- requirements
Module: keypad_matrix_scanner

Interface
REQ-001 Parameter ROW_DWELL, default 1000, clock cycles each row is driven; SHALL be >= 4.
REQ-002 Parameter DEBOUNCE_FRAMES, default 4, consecutive identical full-scan frames required to accept a press or a release.
REQ-003 Parameter REPEAT_FRAMES, default 50, frames between auto-repeat pulses; used only with the macro in REQ-021.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst  input  1  asynchronous, active-low reset.
REQ-006 col_n  input  3  keypad column lines, active-low, externally pulled up, asynchronous to clk.
REQ-007 row_n  output  4  keypad row drive, active-low, at most one bit low.
REQ-008 key_onehot  output  12  debounced key code: bits 0-8 = '1'-'9', bit 9 = '0', bit 10 = '*', bit 11 = '#'.
REQ-009 key_valid  output  1  one-cycle pulse on an accepted press.
REQ-010 key_held  output  1  level, high while a key is accepted and not yet released.

Function
REQ-011 Each col_n bit SHALL pass through a 2-flop synchroniser before use.
REQ-012 Row index SHALL cycle 0,1,2,3,0...; each row is held ROW_DWELL cycles; row_n = ~(1 << index).
REQ-013 Synchronised columns SHALL be sampled only on the last dwell cycle of each row.
REQ-014 Frame vector mapping: row0 cols0-2 -> bits 0-2; row1 -> bits 3-5; row2 -> bits 6-8; row3 col0 -> bit 10, col1 -> bit 9, col2 -> bit 11.
REQ-015 At frame end (last cycle of row 3), candidate = frame vector if popcount <= 1, else 12'h000 (multi-key ignored).
REQ-016 Debounce FSM states IDLE, CONFIRM, HELD, RELEASE, evaluated once per frame end.
  - IDLE: candidate nonzero -> CONFIRM, latch candidate, count = 1.
  - CONFIRM: candidate == latched -> count+1; at count == DEBOUNCE_FRAMES -> HELD. Candidate differs and is nonzero -> relatch, count = 1. Candidate zero -> IDLE.
  - HELD: candidate == latched -> stay; otherwise -> RELEASE, count = 1 if candidate zero, else 0.
  - RELEASE: zero -> count+1; at DEBOUNCE_FRAMES -> IDLE. Candidate == latched -> HELD, no new pulse. Other nonzero -> count = 0.
REQ-017 On CONFIRM->HELD, key_onehot SHALL update and key_valid SHALL pulse in the same cycle, for exactly one cycle.
REQ-018 key_onehot SHALL be zero in IDLE/CONFIRM and hold the latched code in HELD/RELEASE; key_held SHALL be high in HELD/RELEASE.
REQ-019 Press-to-pulse latency SHALL be at most (DEBOUNCE_FRAMES+1) frames plus 3 cycles; frame = 4*ROW_DWELL cycles.

Reset
REQ-020 While rst is low: row_n = 4'b1111, key_onehot = 0, key_valid = 0, key_held = 0, FSM = IDLE, counters = 0, synchronisers = 3'b111; assertion mid-frame SHALL clear immediately; row 0 is driven on the first clock edge after release.

Configuration
REQ-021 Macro KEYPAD_AUTOREPEAT_EN defined: in HELD, key_valid SHALL re-pulse every REPEAT_FRAMES frame ends, counted from the accepting frame, with key_onehot unchanged. Undefined: exactly one pulse per accepted press and no repeat counter is built.

Structure
REQ-022 Package keypad_pkg SHALL hold the 12 one-hot key constants (KEY_1..KEY_0, KEY_STAR, KEY_HASH), the debounce-state enum, and NUM_ROWS = 4, NUM_COLS = 3.
REQ-023 Sub-module keypad_debounce SHALL hold REQ-015..REQ-018 and REQ-021; the top holds synchronisers, row sequencer, and frame assembly.

Verification (ROW_DWELL = 4, DEBOUNCE_FRAMES = 3, REPEAT_FRAMES = 5, frame = 16 cycles)
REQ-024 Hold col_n = 3'b101 only while row_n = 4'b1011, for 5 frames -> one key_valid pulse with key_onehot = 12'h080 ('8'); key_held = 1 until 3 frames after release, then key_onehot = 0.
REQ-025 '5' held 2 frames, released 1 frame, held 2 frames -> no key_valid pulse; FSM never leaves IDLE/CONFIRM.
REQ-026 '1' and '3' pressed together for 6 frames -> no pulse; key_onehot stays 0.
REQ-027 '#' accepted, then 1 zero frame, then '#' again for 5 frames -> single pulse total; key_onehot = 12'h800 throughout.
REQ-028 rst pulled low mid-frame while '*' is held -> row_n = 4'b1111 and all outputs 0 without a clock edge; after release, '*' is re-accepted with a fresh pulse, key_onehot = 12'h400.
REQ-029 KEYPAD_AUTOREPEAT_EN defined, '0' held 20 frames -> pulses at acceptance, +5, +10, +15 frames, key_onehot = 12'h200 each; undefined -> one pulse only.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared keypad definitions: key codes, debounce states and matrix geometry.
// The optional auto-repeat feature is selected with KEYPAD_AUTOREPEAT_EN.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    localparam logic [NUM_KEYS-1:0] KEY_1    = 12'h001;
    localparam logic [NUM_KEYS-1:0] KEY_2    = 12'h002;
    localparam logic [NUM_KEYS-1:0] KEY_3    = 12'h004;
    localparam logic [NUM_KEYS-1:0] KEY_4    = 12'h008;
    localparam logic [NUM_KEYS-1:0] KEY_5    = 12'h010;
    localparam logic [NUM_KEYS-1:0] KEY_6    = 12'h020;
    localparam logic [NUM_KEYS-1:0] KEY_7    = 12'h040;
    localparam logic [NUM_KEYS-1:0] KEY_8    = 12'h080;
    localparam logic [NUM_KEYS-1:0] KEY_9    = 12'h100;
    localparam logic [NUM_KEYS-1:0] KEY_0    = 12'h200;
    localparam logic [NUM_KEYS-1:0] KEY_STAR = 12'h400;
    localparam logic [NUM_KEYS-1:0] KEY_HASH = 12'h800;

    typedef enum logic [1:0] {
        DB_IDLE,
        DB_CONFIRM,
        DB_HELD,
        DB_RELEASE
    } db_state_e;

    // A frame with two or more keys down is ambiguous and is treated as no key.
    function automatic logic at_most_one(input logic [NUM_KEYS-1:0] v);
        return ($countones(v) <= 1);
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-rate debounce FSM producing the accepted key code, press pulse and held level.
// With KEYPAD_AUTOREPEAT_EN defined, key_valid re-pulses every REPEAT_FRAMES frames while held.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 50
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                frame_end,
    input  logic [NUM_KEYS-1:0] frame_vec,
    output logic [NUM_KEYS-1:0] key_onehot,
    output logic                key_valid,
    output logic                key_held
);

    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

    db_state_e           state_q, state_d;
    logic [NUM_KEYS-1:0] latched_q, latched_d;
    logic [NUM_KEYS-1:0] candidate;
    logic [CW-1:0]       count_q, count_d, count_inc;
    logic                valid_q, valid_d;
    logic                cand_zero, cand_same, count_done;

    assign candidate  = at_most_one(frame_vec) ? frame_vec : '0;
    assign cand_zero  = (candidate == '0);
    assign cand_same  = (candidate == latched_q);
    assign count_inc  = count_q + 1'b1;
    assign count_done = (count_inc == CW'(DEBOUNCE_FRAMES));

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_FRAMES + 1);

    logic [RW-1:0] rep_q, rep_d, rep_inc;
    logic          rep_done;

    assign rep_inc  = rep_q + 1'b1;
    assign rep_done = (rep_inc == RW'(REPEAT_FRAMES));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rep_q <= '0;
        end else begin
            rep_q <= rep_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= DB_IDLE;
            latched_q <= '0;
            count_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            latched_q <= latched_d;
            count_q   <= count_d;
            valid_q   <= valid_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        latched_d = latched_q;
        count_d   = count_q;
        valid_d   = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_d     = rep_q;
`endif
        if (frame_end) begin
            case (state_q)
                DB_IDLE: begin
                    if (!cand_zero) begin
                        state_d   = DB_CONFIRM;
                        latched_d = candidate;
                        count_d   = CW'(1);
                    end
                end
                DB_CONFIRM: begin
                    if (cand_zero) begin
                        state_d = DB_IDLE;
                        count_d = '0;
                    end else if (cand_same) begin
                        if (count_done) begin
                            state_d = DB_HELD;
                            count_d = '0;
                            valid_d = 1'b1;
`ifdef KEYPAD_AUTOREPEAT_EN
                            rep_d   = '0;
`endif
                        end else begin
                            count_d = count_inc;
                        end
                    end else begin
                        latched_d = candidate;
                        count_d   = CW'(1);
                    end
                end
                DB_HELD: begin
                    if (!cand_same) begin
                        state_d = DB_RELEASE;
                        count_d = cand_zero ? CW'(1) : '0;
                    end
`ifdef KEYPAD_AUTOREPEAT_EN
                    else if (rep_done) begin
                        valid_d = 1'b1;
                        rep_d   = '0;
                    end else begin
                        rep_d = rep_inc;
                    end
`endif
                end
                DB_RELEASE: begin
                    if (cand_zero) begin
                        if (count_done) begin
                            state_d = DB_IDLE;
                            count_d = '0;
                        end else begin
                            count_d = count_inc;
                        end
                    end else if (cand_same) begin
                        state_d = DB_HELD;
                        count_d = '0;
                    end else begin
                        count_d = '0;
                    end
                end
                default: begin
                    state_d = DB_IDLE;
                    count_d = '0;
                end
            endcase
        end
    end

    assign key_held   = (state_q == DB_HELD) || (state_q == DB_RELEASE);
    assign key_onehot = key_held ? latched_q : '0;
    assign key_valid  = valid_q;

endmodule

// File: rtl/keypad_matrix_scanner.sv
// 4x3 keypad scanner: column synchronisers, row sequencer and frame assembly feeding the debouncer.
// Define KEYPAD_AUTOREPEAT_EN to enable auto-repeat pulses while a key is held.
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int ROW_DWELL       = 1000,
    parameter int DEBOUNCE_FRAMES = 4,
    parameter int REPEAT_FRAMES   = 50
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_COLS-1:0] col_n,
    output logic [NUM_ROWS-1:0] row_n,
    output logic [NUM_KEYS-1:0] key_onehot,
    output logic                key_valid,
    output logic                key_held
);

    localparam int DW = $clog2(ROW_DWELL);

    logic [NUM_COLS-1:0] col_meta, col_sync, pressed;
    logic                running;
    logic [DW-1:0]       dwell_cnt;
    logic [1:0]          row_idx;
    logic                last_dwell, frame_end;
    logic [8:0]          rows_q;
    logic [NUM_KEYS-1:0] frame_vec;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_meta <= '1;
            col_sync <= '1;
        end else begin
            col_meta <= col_n;
            col_sync <= col_meta;
        end
    end

    // 'running' keeps all rows released in reset and starts row 0 on the first edge after it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            running   <= 1'b0;
            dwell_cnt <= '0;
            row_idx   <= '0;
        end else if (!running) begin
            running <= 1'b1;
        end else if (last_dwell) begin
            dwell_cnt <= '0;
            row_idx   <= row_idx + 1'b1;
        end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
        end
    end

    assign last_dwell = running && (dwell_cnt == DW'(ROW_DWELL - 1));
    assign frame_end  = last_dwell && (row_idx == 2'd3);
    assign pressed    = ~col_sync;

    always_comb begin
        row_n = '1;
        if (running) begin
            row_n[row_idx] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rows_q <= '0;
        end else if (last_dwell) begin
            case (row_idx)
                2'd0:    rows_q[2:0] <= pressed;
                2'd1:    rows_q[5:3] <= pressed;
                2'd2:    rows_q[8:6] <= pressed;
                default: ;
            endcase
        end
    end

    // Row 3 is taken live on the frame-end cycle; its keys are '*', '0', '#' left to right.
    assign frame_vec = {pressed[2], pressed[0], pressed[1], rows_q};

    keypad_debounce #(
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
        .REPEAT_FRAMES   (REPEAT_FRAMES)
    ) u_debounce (
        .clk        (clk),
        .rst        (rst),
        .frame_end  (frame_end),
        .frame_vec  (frame_vec),
        .key_onehot (key_onehot),
        .key_valid  (key_valid),
        .key_held   (key_held)
    );

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Directed bench for keypad_matrix_scanner with a behavioural keypad driving col_n from row_n.
// Repeat expectations follow KEYPAD_AUTOREPEAT_EN when it is defined.
`timescale 1ns/1ps
module tb_keypad_matrix_scanner;
    import keypad_pkg::*;

    localparam int ROW_DWELL       = 4;
    localparam int DEBOUNCE_FRAMES = 3;
    localparam int REPEAT_FRAMES   = 5;
    localparam int FRAME           = 4 * ROW_DWELL;
    localparam int MAX_LATENCY     = (DEBOUNCE_FRAMES + 1) * FRAME + 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [2:0]  col_n;
    logic [3:0]  row_n;
    logic [11:0] key_onehot;
    logic        key_valid;
    logic        key_held;

    logic [11:0] keys_down = '0;
    logic        watch_en  = 1'b0;
    logic [11:0] watch_code = '0;

    int checks = 0;
    int passed = 0;
    int cycle = 0;
    int pulse_count = 0;
    int held_cycles = 0;
    int nonzero_cycles = 0;
    int watch_bad = 0;
    logic [11:0] pulse_code = '0;
    int pulse_cycles[$];

    int p0, p1, h0, n0, w0, t0, lat, qn;

    always #5 clk = ~clk;

    keypad_matrix_scanner #(
        .ROW_DWELL       (ROW_DWELL),
        .DEBOUNCE_FRAMES (DEBOUNCE_FRAMES),
        .REPEAT_FRAMES   (REPEAT_FRAMES)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .col_n      (col_n),
        .row_n      (row_n),
        .key_onehot (key_onehot),
        .key_valid  (key_valid),
        .key_held   (key_held)
    );

    function automatic int key_bit(int r, int c);
        if (r < 3) return r * 3 + c;
        else if (c == 0) return 10;
        else if (c == 1) return 9;
        else return 11;
    endfunction

    // Keypad model: a pressed key pulls its column low while its row is driven.
    always_comb begin
        col_n = 3'b111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!row_n[r] && keys_down[key_bit(r, c)]) col_n[c] = 1'b0;
            end
        end
    end

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (key_valid) begin
                pulse_count++;
                pulse_code = key_onehot;
                pulse_cycles.push_back(cycle);
            end
            if (key_held) held_cycles++;
            if (key_onehot != '0) nonzero_cycles++;
            if (watch_en && key_onehot !== watch_code) watch_bad++;
        end
    end

    task automatic applyStimulus(input logic [11:0] keys, input int cycles);
        keys_down = keys;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) passed++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    initial begin
        $display("[TB] reset state");
        repeat (3) @(negedge clk);
        checkOutput("reset_row_n", 32'(row_n), 32'h7 + 32'h8);
        checkOutput("reset_onehot", 32'(key_onehot), 32'h0);
        checkOutput("reset_valid", 32'(key_valid), 32'h0);
        checkOutput("reset_held", 32'(key_held), 32'h0);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("first_row", 32'(row_n), 32'he);

        $display("[TB] key 8 press and release");
        p0 = pulse_count;
        t0 = cycle;
        applyStimulus(KEY_8, 5 * FRAME);
        checkOutput("k8_pulses", 32'(pulse_count), 32'(p0 + 1));
        checkOutput("k8_code", 32'(pulse_code), 32'h080);
        lat = (pulse_cycles.size() > 0) ? pulse_cycles[pulse_cycles.size() - 1] - t0 : 99999;
        checkOutput("k8_latency_ok", 32'(lat <= MAX_LATENCY), 32'h1);
        checkOutput("k8_held", 32'(key_held), 32'h1);
        checkOutput("k8_onehot", 32'(key_onehot), 32'h080);
        applyStimulus('0, 2 * FRAME);
        checkOutput("k8_release_held", 32'(key_held), 32'h1);
        checkOutput("k8_release_onehot", 32'(key_onehot), 32'h080);
        applyStimulus('0, 2 * FRAME);
        checkOutput("k8_idle_held", 32'(key_held), 32'h0);
        checkOutput("k8_idle_onehot", 32'(key_onehot), 32'h0);
        checkOutput("k8_single_pulse", 32'(pulse_count), 32'(p0 + 1));

        $display("[TB] key 5 bounce");
        p0 = pulse_count;
        h0 = held_cycles;
        applyStimulus(KEY_5, 2 * FRAME);
        applyStimulus('0, FRAME);
        applyStimulus(KEY_5, 2 * FRAME);
        applyStimulus('0, 4 * FRAME);
        checkOutput("bounce_pulses", 32'(pulse_count), 32'(p0));
        checkOutput("bounce_held_cycles", 32'(held_cycles), 32'(h0));

        $display("[TB] keys 1 and 3 together");
        p0 = pulse_count;
        n0 = nonzero_cycles;
        applyStimulus(KEY_1 | KEY_3, 6 * FRAME);
        checkOutput("multi_pulses", 32'(pulse_count), 32'(p0));
        checkOutput("multi_onehot_cycles", 32'(nonzero_cycles), 32'(n0));
        applyStimulus('0, 4 * FRAME);

        $display("[TB] key # with one-frame gap");
        p0 = pulse_count;
        applyStimulus(KEY_HASH, 5 * FRAME);
        checkOutput("hash_pulses", 32'(pulse_count), 32'(p0 + 1));
        checkOutput("hash_code", 32'(pulse_code), 32'h800);
        w0 = watch_bad;
        watch_code = KEY_HASH;
        watch_en = 1'b1;
        applyStimulus('0, FRAME);
        applyStimulus(KEY_HASH, 5 * FRAME);
        checkOutput("hash_reheld", 32'(key_held), 32'h1);
        watch_en = 1'b0;
        checkOutput("hash_onehot_steady", 32'(watch_bad), 32'(w0));
        applyStimulus('0, 4 * FRAME);
`ifdef KEYPAD_AUTOREPEAT_EN
        checkOutput("hash_total_pulses", 32'(pulse_count), 32'(p0 + 2));
`else
        checkOutput("hash_total_pulses", 32'(pulse_count), 32'(p0 + 1));
`endif

        $display("[TB] reset while * held");
        p0 = pulse_count;
        applyStimulus(KEY_STAR, 5 * FRAME);
        checkOutput("star_pulses", 32'(pulse_count), 32'(p0 + 1));
        checkOutput("star_onehot", 32'(key_onehot), 32'h400);
        #2 rst = 1'b0;
        #1;
        checkOutput("midrst_row_n", 32'(row_n), 32'hf);
        checkOutput("midrst_onehot", 32'(key_onehot), 32'h0);
        checkOutput("midrst_valid", 32'(key_valid), 32'h0);
        checkOutput("midrst_held", 32'(key_held), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        p1 = pulse_count;
        applyStimulus(KEY_STAR, 5 * FRAME);
        checkOutput("star_again_pulses", 32'(pulse_count), 32'(p1 + 1));
        checkOutput("star_again_code", 32'(pulse_code), 32'h400);
        checkOutput("star_again_held", 32'(key_held), 32'h1);
        applyStimulus('0, 4 * FRAME);

        $display("[TB] key 0 held 20 frames");
        p0 = pulse_count;
        qn = pulse_cycles.size();
        applyStimulus(KEY_0, 20 * FRAME);
        applyStimulus('0, 4 * FRAME);
        checkOutput("k0_code", 32'(pulse_code), 32'h200);
`ifdef KEYPAD_AUTOREPEAT_EN
        checkOutput("k0_pulses", 32'(pulse_count), 32'(p0 + 4));
        for (int i = 1; i < 4; i++) begin
            if (pulse_cycles.size() > qn + i)
                checkOutput("k0_repeat_gap", 32'(pulse_cycles[qn + i] - pulse_cycles[qn + i - 1]), 32'(REPEAT_FRAMES * FRAME));
        end
`else
        checkOutput("k0_pulses", 32'(pulse_count), 32'(p0 + 1));
`endif
        checkOutput("k0_idle_onehot", 32'(key_onehot), 32'h0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
